// File: rtl/quantizer_array_pipe.sv
// Two-stage quantizer for systolic-array partial sums: S1 rounds and shifts, S2 range-reduces.
// Valid/ready on both sides, with a saturating count of overflowing lanes.
module quantizer_array_pipe #(
  parameter int NCH     = 4,
  parameter int IN_W    = 18,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SHIFT_W-1:0]     cfg_shift,
  input  logic                   cfg_round,
  input  logic [1:0]             cfg_mode,
  input  logic                   clr_count,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NCH*IN_W-1:0]    in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NCH*OUT_W-1:0]   out_data,
  output logic [NCH-1:0]         ovf_flags,
  output logic [CNT_W-1:0]       ovf_count
);

  localparam int STAGES = 2;
  localparam int PW     = $clog2(NCH + 1);
  localparam int CW1    = CNT_W + 1;

  // Range bounds at the widened S1 precision; the low OUT_W bits double as clamp values.
  localparam logic signed [IN_W:0] MAXV = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MINV = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic        [IN_W:0] ONE  = {{IN_W{1'b0}}, 1'b1};

  logic [STAGES:1] vld_pipe;
  logic [1:0]      s1_mode;
  logic            s2_open;
  logic            s1_load;
  logic            s2_load;

  assign s2_open   = !vld_pipe[2] || out_ready;
  assign in_ready  = rst_n && (!vld_pipe[1] || s2_open);
  assign s1_load   = in_valid && in_ready;
  assign s2_load   = vld_pipe[1] && s2_open;
  assign out_valid = vld_pipe[2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_mode  <= '0;
    end else begin
      if (in_ready) vld_pipe[1] <= in_valid;
      if (s2_open)  vld_pipe[2] <= vld_pipe[1];
      if (s1_load)  s1_mode     <= cfg_mode;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    logic signed [IN_W:0]  ext;
    logic signed [IN_W:0]  bias;
    logic signed [IN_W:0]  shifted;
    logic signed [IN_W:0]  s1_val;
    logic                  hi;
    logic                  lo;
    logic [OUT_W-1:0]      q;
    logic [OUT_W-1:0]      q_r;
    logic                  f_r;

    // One guard bit keeps the rounding add from overflowing the input range.
    always_comb begin
      ext  = {in_data[k*IN_W+IN_W-1], in_data[k*IN_W +: IN_W]};
      bias = '0;
      if (cfg_round && cfg_shift != '0) bias = ONE << (cfg_shift - 1'b1);
      shifted = (ext + bias) >>> cfg_shift;
    end

    always_comb begin
      hi = s1_val > MAXV;
      lo = s1_val < MINV;
      case (s1_mode)
        2'd0:    q = (hi || lo) ? '0 : s1_val[OUT_W-1:0];
        2'd2:    q = s1_val[OUT_W-1:0];
        default: q = hi ? MAXV[OUT_W-1:0] : (lo ? MINV[OUT_W-1:0] : s1_val[OUT_W-1:0]);
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s1_val <= '0;
        q_r    <= '0;
        f_r    <= 1'b0;
      end else begin
        if (s1_load) s1_val <= shifted;
        if (s2_load) begin
          q_r <= q;
          f_r <= hi || lo;
        end
      end
    end

    assign out_data[k*OUT_W +: OUT_W] = q_r;
    assign ovf_flags[k]               = f_r;
  end

  logic [PW-1:0]  pop;
  logic [CNT_W:0] cnt_sum;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NCH; i++) pop = pop + PW'(ovf_flags[i]);
    cnt_sum = {1'b0, ovf_count} + CW1'(pop);
  end

  // A clear in the same cycle as a handshake discards that beat's events.
  always_ff @(posedge clk) begin
    if (!rst_n)                      ovf_count <= '0;
    else if (clr_count)              ovf_count <= '0;
    else if (out_valid && out_ready) ovf_count <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

endmodule

// File: tb/tb_quantizer_array_pipe.sv
// Bench for quantizer_array_pipe: directed cases, backpressure, counter saturation,
// mid-stream reset and a randomized stream against an integer reference model.
module tb_quantizer_array_pipe;
  localparam int NCH = 4, IN_W = 18, OUT_W = 8, SHIFT_W = 4, CNT_W = 4;
  localparam int MAXC = (1 << CNT_W) - 1;

  logic                 clk, rst_n;
  logic [SHIFT_W-1:0]   cfg_shift;
  logic                 cfg_round;
  logic [1:0]           cfg_mode;
  logic                 clr_count, in_valid, in_ready, out_valid, out_ready;
  logic [NCH*IN_W-1:0]  in_data;
  logic [NCH*OUT_W-1:0] out_data;
  logic [NCH-1:0]       ovf_flags;
  logic [CNT_W-1:0]     ovf_count;

  int checks = 0, errors = 0, exp_cnt = 0;

  typedef struct {
    logic [NCH*OUT_W-1:0] data;
    logic [NCH-1:0]       flags;
  } exp_t;

  quantizer_array_pipe #(.NCH(NCH), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_shift(cfg_shift), .cfg_round(cfg_round), .cfg_mode(cfg_mode),
    .clr_count(clr_count), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .ovf_flags(ovf_flags),
    .ovf_count(ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer arithmetic, floor division, then the overflow policy.
  function automatic exp_t ref_beat(input logic [NCH*IN_W-1:0] d, input int sh, input bit rnd, input int mode);
    exp_t e;
    int v, q, dv, r;
    int lo_b = -(1 << (OUT_W-1));
    int hi_b = (1 << (OUT_W-1)) - 1;
    e.data = '0; e.flags = '0;
    for (int k = 0; k < NCH; k++) begin
      v = int'($signed(d[k*IN_W +: IN_W]));
      if (rnd && sh > 0) v = v + (1 << sh) / 2;
      dv = 1 << sh;
      q = v / dv;
      if (v < 0 && q * dv != v) q = q - 1;
      r = q;
      if (q > hi_b || q < lo_b) begin
        e.flags[k] = 1'b1;
        if (mode == 0)      r = 0;
        else if (mode == 2) r = q;
        else                r = (q > hi_b) ? hi_b : lo_b;
      end
      e.data[k*OUT_W +: OUT_W] = r[OUT_W-1:0];
    end
    return e;
  endfunction

  function automatic int popc(input logic [NCH-1:0] f);
    int n = 0;
    for (int i = 0; i < NCH; i++) n += int'(f[i]);
    return n;
  endfunction

  function automatic int sat_add(input int a, input int b);
    return (a + b > MAXC) ? MAXC : a + b;
  endfunction

  function automatic logic [NCH*IN_W-1:0] pack_in(input int l[4]);
    logic [NCH*IN_W-1:0] r;
    int t;
    for (int k = 0; k < NCH; k++) begin
      t = l[k];
      r[k*IN_W +: IN_W] = t[IN_W-1:0];
    end
    return r;
  endfunction

  function automatic logic [NCH*OUT_W-1:0] pack_out(input int l[4]);
    logic [NCH*OUT_W-1:0] r;
    int t;
    for (int k = 0; k < NCH; k++) begin
      t = l[k];
      r[k*OUT_W +: OUT_W] = t[OUT_W-1:0];
    end
    return r;
  endfunction

  // Drives one beat with out_ready high, returns the output beat and its latency in cycles.
  // Entered and left at posedge+1. lat = -1: never accepted, 99: never emerged.
  task automatic run_beat(input logic [NCH*IN_W-1:0] d, input int sh, input bit rnd, input int mode,
                          input bit clr_on_out, output logic [NCH*OUT_W-1:0] od,
                          output logic [NCH-1:0] of, output int lat);
    int w = 0;
    od = '0; of = '0; lat = -1;
    in_data = d; cfg_shift = sh[SHIFT_W-1:0]; cfg_round = rnd; cfg_mode = mode[1:0];
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    // Scramble config and data after accept: the in-flight beat must not care.
    in_valid = 1'b0;
    in_data = {$urandom, $urandom, $urandom};
    cfg_shift = SHIFT_W'($urandom); cfg_round = 1'($urandom); cfg_mode = 2'($urandom);
    lat = 99;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    od = out_data; of = ovf_flags;
    if (clr_on_out) clr_count = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_count = 1'b0;
    in_data = '0; cfg_shift = '0; cfg_round = 1'b0; cfg_mode = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== '0)    begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    checks++; if (ovf_flags !== '0)   begin errors++; $display("FAIL reset_flags got %b exp 0", ovf_flags); end
    checks++; if (ovf_count !== '0)   begin errors++; $display("FAIL reset_count got %0d exp 0", ovf_count); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_cnt = 0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int li[8][4] = '{'{100,-50,0,127}, '{-128,-129,127,128}, '{300,-300,200,-200}, '{300,-300,200,-200},
                     '{300,-300,200,-200}, '{10,-10,6,-6}, '{10,-10,6,-6}, '{131071,-131072,16384,-1}};
    int lo[8][4] = '{'{100,-50,0,127}, '{-128,0,127,0}, '{127,-128,127,-128}, '{44,-44,-56,56},
                     '{127,-128,127,-128}, '{3,-2,2,-1}, '{2,-3,1,-2}, '{4,-4,1,0}};
    logic [3:0] fl[8] = '{4'b0000, 4'b1010, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    int sh[8] = '{0, 0, 0, 0, 0, 2, 2, 15};
    bit rn[8] = '{0, 0, 0, 0, 0, 1, 0, 1};
    int md[8] = '{0, 0, 1, 2, 3, 1, 1, 1};
    logic [NCH*OUT_W-1:0] od, ed;
    logic [NCH-1:0] of;
    int lat;
    for (int r = 0; r < 8; r++) begin
      run_beat(pack_in(li[r]), sh[r], rn[r], md[r], 1'b0, od, of, lat);
      ed = pack_out(lo[r]);
      exp_cnt = sat_add(exp_cnt, popc(fl[r]));
      checks++; if (lat !== 2)      begin errors++; $display("FAIL dir%0d_latency got %0d exp 2", r, lat); end
      checks++; if (od !== ed)      begin errors++; $display("FAIL dir%0d_data got %h exp %h", r, od, ed); end
      checks++; if (of !== fl[r])   begin errors++; $display("FAIL dir%0d_flags got %b exp %b", r, of, fl[r]); end
      checks++; if (ovf_count !== CNT_W'(exp_cnt))
        begin errors++; $display("FAIL dir%0d_count got %0d exp %0d", r, ovf_count, exp_cnt); end
    end
  endtask

  task automatic test_backpressure();
    int a[4] = '{300,-300,200,-200};
    int b[4] = '{100,-50,0,127};
    int c[4] = '{-128,-129,127,128};
    exp_t ea, eb, ec;
    ea = ref_beat(pack_in(a), 0, 0, 1);
    eb = ref_beat(pack_in(b), 0, 0, 0);
    ec = ref_beat(pack_in(c), 0, 0, 0);
    cfg_shift = '0; cfg_round = 1'b0; out_ready = 1'b0;
    cfg_mode = 2'd1; in_data = pack_in(a); in_valid = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept_a got %b exp 1", in_ready); end
    @(posedge clk); #1;
    cfg_mode = 2'd0; in_data = pack_in(b);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept_b got %b exp 1", in_ready); end
    @(posedge clk); #1;
    in_data = pack_in(c);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL bp_full_in_ready cyc%0d got %b exp 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1)  begin errors++; $display("FAIL bp_hold_valid cyc%0d got %b exp 1", i, out_valid); end
      checks++; if (out_data !== ea.data) begin errors++; $display("FAIL bp_hold_data cyc%0d got %h exp %h", i, out_data, ea.data); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL bp_release_in_ready got %b exp 1", in_ready); end
    checks++; if (out_data !== ea.data) begin errors++; $display("FAIL bp_out_a got %h exp %h", out_data, ea.data); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (!out_valid || out_data !== eb.data || ovf_flags !== eb.flags)
      begin errors++; $display("FAIL bp_out_b got v%b %h/%b exp %h/%b", out_valid, out_data, ovf_flags, eb.data, eb.flags); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (!out_valid || out_data !== ec.data || ovf_flags !== ec.flags)
      begin errors++; $display("FAIL bp_out_c got v%b %h/%b exp %h/%b", out_valid, out_data, ovf_flags, ec.data, ec.flags); end
    @(posedge clk); #1;
    @(negedge clk);
    exp_cnt = sat_add(sat_add(sat_add(exp_cnt, popc(ea.flags)), popc(eb.flags)), popc(ec.flags));
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b exp 0", out_valid); end
    checks++; if (ovf_count !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL bp_count got %0d exp %0d", ovf_count, exp_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_counter();
    int a[4] = '{300,-300,200,-200};
    logic [NCH*OUT_W-1:0] od;
    logic [NCH-1:0] of;
    int lat, bad = 0;
    clr_count = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    checks++; if (ovf_count !== '0) begin errors++; $display("FAIL cnt_clear got %0d exp 0", ovf_count); end
    for (int i = 0; i < 9; i++) begin
      run_beat(pack_in(a), 0, 0, 1, 1'b0, od, of, lat);
      if (lat != 2) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL cnt_beats_latency got %0d bad exp 0", bad); end
    checks++; if (ovf_count !== CNT_W'(MAXC)) begin errors++; $display("FAIL cnt_saturate got %0d exp %0d", ovf_count, MAXC); end
    run_beat(pack_in(a), 0, 0, 1, 1'b1, od, of, lat);
    exp_cnt = 0;
    checks++; if (lat !== 2)  begin errors++; $display("FAIL cnt_clr_beat_latency got %0d exp 2", lat); end
    checks++; if (ovf_count !== '0) begin errors++; $display("FAIL cnt_clr_wins got %0d exp 0", ovf_count); end
  endtask

  task automatic test_reset_midstream();
    int a[4] = '{300,-300,200,-200};
    int b[4] = '{10,-10,6,-6};
    logic [NCH*OUT_W-1:0] od;
    logic [NCH-1:0] of;
    exp_t eb;
    int lat, stale = 0;
    out_ready = 1'b0; cfg_shift = '0; cfg_round = 1'b0; cfg_mode = 2'd1;
    in_data = pack_in(a); in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_inflight got %b exp 1", out_valid); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL mid_reset_in_ready got %b exp 0", in_ready); end
    checks++; if (ovf_count !== '0)   begin errors++; $display("FAIL mid_reset_count got %0d exp 0", ovf_count); end
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1; exp_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
      @(posedge clk); #1;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL mid_stale_beats got %0d exp 0", stale); end
    eb = ref_beat(pack_in(b), 2, 1, 1);
    run_beat(pack_in(b), 2, 1, 1, 1'b0, od, of, lat);
    checks++; if (lat !== 2 || od !== eb.data)
      begin errors++; $display("FAIL mid_recover got lat%0d %h exp lat2 %h", lat, od, eb.data); end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    int v, inc;
    bit hs;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (i < 580) begin
        in_valid = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < NCH; k++) begin
          v = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 800)) - 400;
          in_data[k*IN_W +: IN_W] = v[IN_W-1:0];
        end
        cfg_shift = ($urandom_range(0, 3) == 0) ? SHIFT_W'($urandom) : SHIFT_W'($urandom_range(0, 3));
        cfg_round = 1'($urandom);
        cfg_mode  = 2'($urandom);
        out_ready = ($urandom_range(0, 3) != 0);
        clr_count = ($urandom_range(0, 40) == 0);
      end else begin
        in_valid = 1'b0; out_ready = 1'b1; clr_count = 1'b0;
      end
      @(negedge clk);
      checks++; if (ovf_count !== CNT_W'(exp_cnt))
        begin errors++; $display("FAIL rnd_count cyc%0d got %0d exp %0d", i, ovf_count, exp_cnt); end
      hs = out_valid && out_ready;
      inc = 0;
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rnd_unexpected_beat cyc%0d got %h", i, out_data);
        end else if (out_data !== q[0].data || ovf_flags !== q[0].flags) begin
          errors++; $display("FAIL rnd_beat cyc%0d got %h/%b exp %h/%b", i, out_data, ovf_flags, q[0].data, q[0].flags);
        end
        if (hs && q.size() != 0) begin
          e = q.pop_front();
          inc = popc(e.flags);
        end
      end
      if (clr_count)  exp_cnt = 0;
      else if (hs)    exp_cnt = sat_add(exp_cnt, inc);
      if (in_valid && in_ready) q.push_back(ref_beat(in_data, int'(cfg_shift), cfg_round, int'(cfg_mode)));
      if (q.size() > 2) begin
        checks++; errors++; $display("FAIL rnd_capacity cyc%0d got %0d beats exp <=2", i, q.size());
      end
    end
    clr_count = 1'b0;
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_drain got %0d pending exp 0", q.size()); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_counter();
    test_random();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
